// File: rtl/router_ctrl_if.sv
// Source-port and FIFO-side signals of the router controller, grouped
// so the controller and its environment share one connection bundle.
interface router_ctrl_if;
  // Source side
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       busy;
  logic       err;

  // FIFO side
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] read_enb;
  logic [2:0] vld_out;
  logic [2:0] write_enb;
  logic [2:0] soft_rst;
  logic [7:0] dout;
  logic       lfd_state;

  // Environment view: drives the byte stream and the FIFO status
  modport master (
    output pkt_valid, data_in, full, empty, read_enb,
    input  busy, err, dout, write_enb, lfd_state, soft_rst, vld_out
  );

  // Controller view
  modport slave (
    input  pkt_valid, data_in, full, empty, read_enb,
    output busy, err, dout, write_enb, lfd_state, soft_rst, vld_out
  );
endinterface

// File: rtl/router_ctrl.sv
// Packet controller for three output FIFOs: decodes the header, steers
// header/payload/parity into the addressed FIFO, checks parity, and
// soft-resets any FIFO whose reader has been idle for TIMEOUT cycles.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic         clk,
  input  logic         rstn,
  router_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE      = 3'd0,
    WAIT_EMPTY  = 3'd1,
    LOAD_FIRST  = 3'd2,
    LOAD_DATA   = 3'd3,
    LOAD_PARITY = 3'd4,
    CHECK       = 3'd5,
    DROP        = 3'd6
  } state_t;

  // Timer value at the start of the TIMEOUT-th consecutive idle cycle
  localparam logic [4:0] TMR_LAST = 5'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [1:0] addr_reg, addr_next;
  logic [7:0] hdr_reg, hdr_next;
  logic [5:0] rem_reg, rem_next;
  logic [7:0] par_reg, par_next;
  logic [6:0] drop_reg, drop_next;   // bytes still to discard in DROP
  logic       err_reg, err_next;

  logic [4:0] tmr_reg  [3];
  logic [4:0] tmr_next [3];
  logic [2:0] soft_rst_reg, soft_rst_next;
  logic [2:0] idle;
  logic [2:0] expire;

  // Address-indexed views; bit 3 covers the invalid address safely
  logic [3:0] full_ext, empty_ext, soft_ext;
  logic       full_sel, empty_sel, hdr_empty, abort, take_load;
  logic [2:0] addr_onehot;

  logic       busy;
  logic       wr;
  logic       lfd;
  logic [7:0] dout;

  assign full_ext    = {1'b0, bus.full};
  assign empty_ext   = {1'b0, bus.empty};
  assign soft_ext    = {1'b0, soft_rst_reg};
  assign full_sel    = full_ext[addr_reg];
  assign empty_sel   = empty_ext[addr_reg];
  assign hdr_empty   = empty_ext[bus.data_in[1:0]];
  assign abort       = soft_ext[addr_reg];
  assign addr_onehot = 3'b001 << addr_reg;
  // A byte is taken while loading whenever the source offers one and the
  // target FIFO has room (busy is exactly full_sel in those states)
  assign take_load   = bus.pkt_valid & ~full_sel;

  assign bus.busy      = busy;
  assign bus.write_enb = wr ? addr_onehot : 3'b000;
  assign bus.dout      = dout;
  assign bus.lfd_state = lfd;
  assign bus.err       = err_reg;
  assign bus.soft_rst  = soft_rst_reg;
  assign bus.vld_out   = ~bus.empty;

  // Next-state, datapath updates and handshake outputs of the packet FSM
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    hdr_next   = hdr_reg;
    rem_next   = rem_reg;
    par_next   = par_reg;
    drop_next  = drop_reg;
    err_next   = 1'b0;
    busy       = 1'b1;
    wr         = 1'b0;
    lfd        = 1'b0;
    dout       = 8'h00;

    case (state_reg)
      DECODE: begin
        busy = 1'b0;
        if (bus.pkt_valid) begin
          hdr_next  = bus.data_in;
          addr_next = bus.data_in[1:0];
          rem_next  = bus.data_in[7:2];
          par_next  = bus.data_in;
          if (bus.data_in[1:0] == 2'd3) begin
            // Payload plus parity are discarded
            state_next = DROP;
            drop_next  = {1'b0, bus.data_in[7:2]} + 7'd1;
          end else if (hdr_empty) begin
            state_next = LOAD_FIRST;
            lfd        = 1'b1;
          end else begin
            state_next = WAIT_EMPTY;
          end
        end
      end

      WAIT_EMPTY: begin
        if (abort) begin
          state_next = DROP;
          drop_next  = {1'b0, rem_reg} + 7'd1;
        end else if (empty_sel) begin
          state_next = LOAD_FIRST;
          lfd        = 1'b1;
        end
      end

      LOAD_FIRST: begin
        dout = hdr_reg;
        if (abort) begin
          state_next = DROP;
          drop_next  = {1'b0, rem_reg} + 7'd1;
        end else begin
          wr = 1'b1;
          if (rem_reg != 6'd0) begin
            state_next = LOAD_DATA;
          end else begin
            state_next = LOAD_PARITY;
          end
        end
      end

      LOAD_DATA: begin
        busy = full_sel;
        dout = bus.data_in;
        if (abort) begin
          // A byte taken in the abort cycle is already consumed
          state_next = DROP;
          drop_next  = take_load ? {1'b0, rem_reg} : ({1'b0, rem_reg} + 7'd1);
        end else if (take_load) begin
          wr       = 1'b1;
          par_next = par_reg ^ bus.data_in;
          rem_next = rem_reg - 6'd1;
          if (rem_reg == 6'd1) begin
            state_next = LOAD_PARITY;
          end
        end
      end

      LOAD_PARITY: begin
        busy = full_sel;
        dout = bus.data_in;
        if (abort) begin
          if (take_load) begin
            state_next = DECODE;
          end else begin
            state_next = DROP;
            drop_next  = 7'd1;
          end
        end else if (take_load) begin
          wr         = 1'b1;
          err_next   = (bus.data_in != par_reg);
          state_next = CHECK;
        end
      end

      CHECK: begin
        state_next = DECODE;
      end

      DROP: begin
        busy = 1'b0;
        if (bus.pkt_valid) begin
          drop_next = drop_reg - 7'd1;
          if (drop_reg == 7'd1) begin
            state_next = DECODE;
          end
        end
      end

      default: begin
        state_next = DECODE;
      end
    endcase
  end

  // Packet FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= DECODE;
      addr_reg  <= 2'd0;
      hdr_reg   <= 8'h00;
      rem_reg   <= 6'd0;
      par_reg   <= 8'h00;
      drop_reg  <= 7'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      hdr_reg   <= hdr_next;
      rem_reg   <= rem_next;
      par_reg   <= par_next;
      drop_reg  <= drop_next;
      err_reg   <= err_next;
    end
  end

  // Per-FIFO idle detection: count unread cycles, fire on the last one
  for (genvar gi = 0; gi < 3; gi++) begin : g_tmr
    assign idle[gi]          = bus.vld_out[gi] & ~bus.read_enb[gi];
    assign expire[gi]        = idle[gi] & (tmr_reg[gi] == TMR_LAST);
    assign tmr_next[gi]      = (idle[gi] & ~expire[gi]) ? (tmr_reg[gi] + 5'd1) : 5'd0;
    assign soft_rst_next[gi] = expire[gi];
  end

  // Idle timers and the one-cycle soft-reset pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        tmr_reg[i] <= 5'd0;
      end
      soft_rst_reg <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        tmr_reg[i] <= tmr_next[i];
      end
      soft_rst_reg <= soft_rst_next;
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl with a behavioural model of the three
// 16-entry FIFOs closing the full/empty loop.
module tb_router_ctrl;

  logic clk;
  logic rstn;
  router_ctrl_if bus();

  router_ctrl #(.TIMEOUT(30)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO models
  logic [7:0] f_mem [3][16];
  logic [3:0] f_wp [3];
  logic [3:0] f_rp [3];
  int         f_cnt [3];
  int         wr_cnt [3];
  logic [2:0] m_full, m_empty;

  logic [7:0] t1_bytes [5];
  logic [7:0] pb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 16-entry FIFOs; soft_rst clears a FIFO at the clock edge
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      m_full[i]  = (f_cnt[i] == 16);
      m_empty[i] = (f_cnt[i] == 0);
    end
  end
  assign bus.full  = m_full;
  assign bus.empty = m_empty;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bus.write_enb[i]) wr_cnt[i] <= wr_cnt[i] + 1;
      if (!rstn || bus.soft_rst[i]) begin
        f_cnt[i] <= 0;
        f_wp[i]  <= 4'd0;
        f_rp[i]  <= 4'd0;
      end else begin
        if (bus.write_enb[i] && !m_full[i]) begin
          f_mem[i][f_wp[i]] <= bus.dout;
          f_wp[i] <= f_wp[i] + 4'd1;
        end
        if (bus.read_enb[i] && !m_empty[i]) f_rp[i] <= f_rp[i] + 4'd1;
        f_cnt[i] <= f_cnt[i] + ((bus.write_enb[i] && !m_full[i]) ? 1 : 0)
                             - ((bus.read_enb[i] && !m_empty[i]) ? 1 : 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte that must be accepted this cycle
  task automatic push(input string tag, input logic [7:0] b,
                      input logic [2:0] exp_we, input logic exp_lfd);
    bus.pkt_valid = 1'b1;
    bus.data_in   = b;
    #1;
    chk1({tag, ".busy"}, bus.busy, 1'b0);
    chk3({tag, ".we"}, bus.write_enb, exp_we);
    chk1({tag, ".lfd"}, bus.lfd_state, exp_lfd);
    chk1({tag, ".err"}, bus.err, 1'b0);
    if (exp_we != 3'b000) chk8({tag, ".dout"}, bus.dout, b);
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  // Header write cycle: source held off, header goes to the FIFO
  task automatic load_first(input string tag, input logic [7:0] hdr, input logic [2:0] exp_we);
    bus.pkt_valid = 1'b0;
    #1;
    chk1({tag, ".busy"}, bus.busy, 1'b1);
    chk3({tag, ".we"}, bus.write_enb, exp_we);
    chk8({tag, ".dout"}, bus.dout, hdr);
    chk1({tag, ".lfd"}, bus.lfd_state, 1'b0);
    tick();
  endtask

  // CHECK cycle then the following DECODE cycle
  task automatic check_cycle(input string tag, input logic exp_err);
    bus.pkt_valid = 1'b0;
    #1;
    chk1({tag, ".busy"}, bus.busy, 1'b1);
    chk1({tag, ".err"}, bus.err, exp_err);
    chk3({tag, ".we"}, bus.write_enb, 3'b000);
    tick();
    chk1({tag, ".err_after"}, bus.err, 1'b0);
    chk1({tag, ".busy_after"}, bus.busy, 1'b0);
  endtask

  // Source offering a byte while the target FIFO is full
  task automatic stall(input string tag, input logic [7:0] b, input logic [2:0] exp_soft);
    bus.pkt_valid = 1'b1;
    bus.data_in   = b;
    #1;
    chk1({tag, ".busy"}, bus.busy, 1'b1);
    chk3({tag, ".we"}, bus.write_enb, 3'b000);
    chk3({tag, ".soft"}, bus.soft_rst, exp_soft);
    tick();
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    bus.read_enb[i] = 1'b1;
    while (bus.empty[i] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    bus.read_enb[i] = 1'b0;
    chk1($sformatf("drain%0d", i), bus.empty[i], 1'b1);
  endtask

  initial begin
    wr_cnt = '{0, 0, 0};
    t1_bytes = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'hAD};
    bus.pkt_valid = 1'b0;
    bus.data_in   = 8'h00;
    bus.read_enb  = 3'b000;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
    chk1("rst.busy", bus.busy, 1'b0);
    chk3("rst.we", bus.write_enb, 3'b000);
    chk1("rst.lfd", bus.lfd_state, 1'b0);
    chk8("rst.dout", bus.dout, 8'h00);
    chk1("rst.err", bus.err, 1'b0);
    chk3("rst.soft", bus.soft_rst, 3'b000);
    chk3("rst.vld", bus.vld_out, 3'b000);
    $display("txn reset");

    // Addr 1, length 3, good parity 0x0D^A1^A2^A3 = 0xAD
    push("t1.hdr", 8'h0D, 3'b000, 1'b1);
    load_first("t1.first", 8'h0D, 3'b010);
    push("t1.p0", 8'hA1, 3'b010, 1'b0);
    push("t1.p1", 8'hA2, 3'b010, 1'b0);
    push("t1.p2", 8'hA3, 3'b010, 1'b0);
    push("t1.par", 8'hAD, 3'b010, 1'b0);
    check_cycle("t1.chk", 1'b0);
    chkn("t1.nwr", wr_cnt[1], 5);
    chk3("t1.vld", bus.vld_out, 3'b010);
    for (int k = 0; k < 5; k++)
      chk8($sformatf("t1.fifo%0d", k), f_mem[1][4'(int'(f_rp[1]) + k)], t1_bytes[k]);
    $display("txn pkt addr=1 len=3 good parity");
    drain(1);

    // Same packet, parity corrupted
    push("t2.hdr", 8'h0D, 3'b000, 1'b1);
    load_first("t2.first", 8'h0D, 3'b010);
    push("t2.p0", 8'hA1, 3'b010, 1'b0);
    push("t2.p1", 8'hA2, 3'b010, 1'b0);
    push("t2.p2", 8'hA3, 3'b010, 1'b0);
    push("t2.par", 8'hAE, 3'b010, 1'b0);
    check_cycle("t2.chk", 1'b1);
    chkn("t2.nwr", wr_cnt[1], 10);
    $display("txn pkt addr=1 len=3 bad parity");
    drain(1);

    // Invalid address 3, length 2: four bytes dropped
    push("t3.hdr", 8'h0B, 3'b000, 1'b0);
    push("t3.d0", 8'hC1, 3'b000, 1'b0);
    push("t3.d1", 8'hC2, 3'b000, 1'b0);
    push("t3.d2", 8'hC3, 3'b000, 1'b0);
    // Then addr 2, length 2, parity 0x0A^11^22 = 0x39
    push("t3b.hdr", 8'h0A, 3'b000, 1'b1);
    load_first("t3b.first", 8'h0A, 3'b100);
    push("t3b.p0", 8'h11, 3'b100, 1'b0);
    push("t3b.p1", 8'h22, 3'b100, 1'b0);
    push("t3b.par", 8'h39, 3'b100, 1'b0);
    check_cycle("t3b.chk", 1'b0);
    chkn("t3.nwr0", wr_cnt[0], 0);
    chkn("t3.nwr2", wr_cnt[2], 4);
    $display("txn drop addr=3 then pkt addr=2 len=2");

    // FIFO 2 timeout: read at idle cycle 29 prevents it, then 30 idle fire
    bus.read_enb[2] = 1'b1;
    #1;
    chk3("t5.r0.soft", bus.soft_rst, 3'b000);
    tick();
    bus.read_enb[2] = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      chk3($sformatf("t5.a%0d.soft", k), bus.soft_rst, 3'b000);
      tick();
    end
    bus.read_enb[2] = 1'b1;
    #1;
    chk3("t5.a29.soft", bus.soft_rst, 3'b000);
    tick();
    bus.read_enb[2] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      chk3($sformatf("t5.b%0d.soft", k), bus.soft_rst, 3'b000);
      tick();
    end
    chk3("t5.pulse", bus.soft_rst, 3'b100);
    tick();
    chk3("t5.pulse_end", bus.soft_rst, 3'b000);
    chk1("t5.vld2", bus.vld_out[2], 1'b0);
    $display("txn timeout fifo 2");

    // Addr 0, length 20, reader idle: fill, one read, then timeout abort
    push("t4.hdr", 8'h50, 3'b000, 1'b1);
    load_first("t4.first", 8'h50, 3'b001);
    for (int k = 0; k < 15; k++) begin
      pb = 8'h80 + 8'(k);
      push($sformatf("t4.p%0d", k), pb, 3'b001, 1'b0);
    end
    for (int s = 0; s < 3; s++) stall($sformatf("t4.full%0d", s), 8'h8F, 3'b000);
    bus.read_enb[0] = 1'b1;
    stall("t4.read", 8'h8F, 3'b000);
    bus.read_enb[0] = 1'b0;
    push("t4.resume", 8'h8F, 3'b001, 1'b0);
    for (int k = 0; k < 16; k++) begin
      pb = 8'h80 + 8'(k);
      chk8($sformatf("t4.fifo%0d", k), f_mem[0][4'(int'(f_rp[0]) + k)], pb);
    end
    for (int s = 2; s <= 30; s++) stall($sformatf("t4.idle%0d", s), 8'h90, 3'b000);
    stall("t4.abort", 8'h90, 3'b001);
    chk1("t4.vld0", bus.vld_out[0], 1'b0);
    push("t4.d16", 8'h90, 3'b000, 1'b0);
    push("t4.d17", 8'h91, 3'b000, 1'b0);
    push("t4.d18", 8'h92, 3'b000, 1'b0);
    push("t4.d19", 8'h93, 3'b000, 1'b0);
    push("t4.dpar", 8'h55, 3'b000, 1'b0);
    chkn("t4.nwr0", wr_cnt[0], 17);
    $display("txn pkt addr=0 len=20 aborted by timeout");

    // Addr 1, length 0: parity equals the header
    push("t6.hdr", 8'h01, 3'b000, 1'b1);
    load_first("t6.first", 8'h01, 3'b010);
    push("t6.par", 8'h01, 3'b010, 1'b0);
    check_cycle("t6.chk", 1'b0);
    chkn("t6.nwr1", wr_cnt[1], 12);
    $display("txn pkt addr=1 len=0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_ctrl.md
# router_ctrl

Packet-level controller for the router's three 16-entry output FIFOs. It takes the source byte stream, decodes the header, and steers header, payload and parity bytes into one FIFO. It drives each FIFO's write enable, first-byte marker and soft reset, checks packet parity, and frees any FIFO whose reader stalls for 30 cycles. It sits between the source port and the three FIFO instances; each FIFO's outputs feed back into this block.

## Interface
- `TIMEOUT`, default 30: consecutive unread cycles before a FIFO is soft-reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: reset, synchronous and active-low.
- `pkt_valid` in 1: the source presents a byte on `data_in`.
- `data_in` in 8: packet byte stream.
  - Header byte: [7:2] is the payload length (0..63); [1:0] is the address (0..2 valid, 3 invalid).
  - Then the payload bytes, then one parity byte.
- `full` in 3: per-FIFO full flags.
- `empty` in 3: per-FIFO empty flags.
- `read_enb` in 3: per-FIFO read strobes from the output ports.
- `dout` out 8: write data, common to all FIFOs.
- `write_enb` out 3: one-hot FIFO write enable.
- `lfd_state` out 1: asserted the cycle before the header is written.
- `soft_rst` out 3: per-FIFO one-cycle soft reset.
- `vld_out` out 3: equals `~empty`; combinational.
- `busy` out 1: the source must hold its byte; a byte is accepted only when `pkt_valid & ~busy`.
- `err` out 1: one-cycle parity-mismatch pulse.

## Operation
- Registers:
  - `addr` (2 bits): latched target FIFO.
  - `hdr` (8 bits): latched header byte.
  - `rem` (6 bits): remaining payload bytes.
  - `par` (8 bits): running XOR.
  - `tmr[i]` (5 bits): per-FIFO idle counter.
- FSM states:
  - DECODE: `busy`=0. On an accepted byte:
    - latch `hdr`, `addr`=[1:0], `rem`=[7:2], `par`=byte;
    - if addr is 3, go to DROP with a byte budget of `rem`+1;
    - else if `empty[addr]`, go to LOAD_FIRST;
    - else go to WAIT_EMPTY.
  - WAIT_EMPTY: `busy`=1. Go to LOAD_FIRST when `empty[addr]`=1.
  - LOAD_FIRST: `busy`=1.
    - `dout`=`hdr`, `write_enb[addr]`=1; the FIFO is empty, so it cannot be full.
    - Go to LOAD_DATA if `rem`≠0, else to LOAD_PARITY.
  - LOAD_DATA: `busy`=`full[addr]`.
    - `dout`=`data_in`; `write_enb[addr]`=`pkt_valid & ~full[addr]`.
    - Each write: `par` ^= byte, `rem`--.
    - Go to LOAD_PARITY after the write made with `rem`=1.
  - LOAD_PARITY: `busy`=`full[addr]`.
    - The parity byte is written to the FIFO like a payload byte.
    - On write, go to CHECK and register `err` = (byte ≠ `par`).
  - CHECK: `busy`=1; `err` is high this cycle only. Go to DECODE.
  - DROP: `busy`=0, no writes. Count accepted bytes; go to DECODE after the last one. `err` stays 0.
- `lfd_state` is combinational. It is 1 exactly in cycles whose next state is LOAD_FIRST, i.e. a DECODE accept with the FIFO empty, or WAIT_EMPTY with `empty[addr]`=1. This matches the FIFO's internal one-cycle delay of the marker.
- `write_enb` is 0 outside LOAD_FIRST, LOAD_DATA and LOAD_PARITY. `dout` is 0 in all other states.
- Timeout, per FIFO i:
  - `tmr[i]` increments each cycle `vld_out[i] & ~read_enb[i]`; otherwise it clears.
  - At the edge ending the `TIMEOUT`-th consecutive idle cycle: `soft_rst[i]` is registered high for one cycle and `tmr[i]` clears.
- Abort: `soft_rst[addr]` high while in WAIT_EMPTY, LOAD_FIRST, LOAD_DATA or LOAD_PARITY sends the FSM to DROP.
  - The byte budget is the packet's remaining bytes, including parity.
  - No further writes; `err` stays 0.

## Timing
- Reset (`rstn`=0 at an edge): FSM to DECODE; all registers 0.
  - After reset: `soft_rst`=0, `err`=0, `busy`=0, `write_enb`=0, `lfd_state`=0, `dout`=0.
  - `vld_out` tracks `empty` even during reset.
- Reset mid-packet: the rest of the stream is treated as new headers. Source and FIFOs are reset together.
- Header accept to header write: 1 cycle, or more via WAIT_EMPTY. The source always sees `busy`=1 for one cycle after the header.
- Payload writes are zero-latency: `write_enb` and `dout` are valid in the same cycle the byte is accepted.
- Full during LOAD_DATA or LOAD_PARITY: stall with no write; resume on the first cycle `full[addr]`=0.
- Parity write to `err`: `err` is visible the next cycle (CHECK).
- The next header is accepted no earlier than 2 cycles after the parity write.
- Timeout vs read: `read_enb[i]` in the cycle the count would reach `TIMEOUT` clears the counter; no `soft_rst`.
- Simultaneous timeouts on several FIFOs: each fires independently.

## Test plan
- Packet to addr 1, length 3, correct parity, all FIFOs empty:
  - `lfd_state`=1 for one cycle, then `write_enb`=3'b010 for 5 bytes;
  - header first; `busy` high for exactly 1 cycle mid-packet; `err`=0.
- Same packet with the parity byte corrupted: 5 writes, then `err`=1 for exactly one cycle in CHECK.
- Length-20 packet to addr 0 while its reader is idle:
  - `full[0]` rises after 16 entries, so `busy`=1 and writes stop;
  - one read then resumes the stream with no lost or duplicated byte.
- Header with addr 3, length 2: 4 bytes accepted, no `write_enb`, returns to DECODE; the next valid packet loads normally.
- FIFO 2 non-empty with `read_enb[2]`=0 for 30 cycles:
  - `soft_rst[2]` pulses once;
  - a read strobe at idle cycle 29 prevents the pulse.
- Timeout on the FIFO being loaded mid-payload: FSM goes to DROP, consumes the remaining bytes including parity, no writes, `err`=0.
